// File: rtl/transpose_output_scheduler_if.sv
// Handshake bundle between Control Top and the transpose output scheduler.
//
// master : drain requester (Control Top / testbench)
//   start, num_cols, stall, abort -> scheduler
//   en_output, cur_col, busy, done <- scheduler
// slave  : the scheduler itself, sole driver of en_output
interface transpose_output_scheduler_if #(
  parameter int Dimension = 16,
  parameter int CNT_W     = 5
);
  logic                 start;
  logic [CNT_W-1:0]     num_cols;
  logic                 stall;
  logic                 abort;
  logic [Dimension-1:0] en_output;
  logic [3:0]           cur_col;
  logic                 busy;
  logic                 done;

  modport master (
    output start, num_cols, stall, abort,
    input  en_output, cur_col, busy, done
  );

  modport slave (
    input  start, num_cols, stall, abort,
    output en_output, cur_col, busy, done
  );
endinterface

// File: rtl/transpose_output_scheduler.sv
// Transpose output scheduler: drains the systolic array column by column.
//
// On an accepted start it walks a one-hot en_output from column 0 up to the
// latched column count, pausing while downstream stalls, then spends one
// cycle covering the output-sync latency and pulses done for one cycle.
//
// Ports:
//   clk    : clock
//   rst_n  : asynchronous active-low reset
//   bus    : slave side of transpose_output_scheduler_if
//            (start, num_cols, stall, abort in; en_output, cur_col,
//             busy, done out, all outputs registered)
module transpose_output_scheduler #(
  parameter int Dimension = 16,
  parameter int CNT_W     = 5
) (
  input  logic                          clk,
  input  logic                          rst_n,
  transpose_output_scheduler_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, DRAIN, FLUSH, DONE} state_t;

  state_t               state_q;
  logic [CNT_W-1:0]     n_q;
  logic [CNT_W-1:0]     idx_q;
  logic [Dimension-1:0] en_q;
  logic [3:0]           col_q;
  logic                 busy_q;
  logic                 done_q;

  // Requested column count clamped to the physical array width; this is the
  // value n_q takes on an accepted start.
  logic [CNT_W-1:0]     n_d;
  assign n_d = (bus.num_cols > CNT_W'(Dimension)) ? CNT_W'(Dimension) : bus.num_cols;

  // idx_q always points at the next column still to be issued. The first
  // column is issued straight from IDLE, so DRAIN starts with idx_q = 1.
  // Once idx_q reaches n_q the last column is already on en_output and the
  // FSM moves to FLUSH regardless of stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      n_q     <= '0;
      idx_q   <= '0;
      en_q    <= '0;
      col_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else if (bus.abort) begin
      state_q <= IDLE;
      n_q     <= '0;
      idx_q   <= '0;
      en_q    <= '0;
      col_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          en_q   <= '0;
          done_q <= 1'b0;
          busy_q <= 1'b0;
          if (bus.start) begin
            n_q    <= n_d;
            busy_q <= 1'b1;
            if (n_d == '0) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= DRAIN;
              en_q    <= Dimension'(1);
              col_q   <= '0;
              idx_q   <= CNT_W'(1);
            end
          end
        end

        DRAIN: begin
          if (idx_q == n_q) begin
            state_q <= FLUSH;
            en_q    <= '0;
          end else if (bus.stall) begin
            en_q <= '0;
          end else begin
            en_q  <= Dimension'(1) << idx_q;
            col_q <= idx_q[3:0];
            idx_q <= idx_q + CNT_W'(1);
          end
        end

        FLUSH: begin
          state_q <= DONE;
          done_q  <= 1'b1;
        end

        DONE: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          col_q   <= '0;
          idx_q   <= '0;
        end

        default: begin
          state_q <= IDLE;
          en_q    <= '0;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.en_output = en_q;
  assign bus.cur_col   = col_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;

endmodule

// File: tb/tb_transpose_output_scheduler.sv
// Testbench for transpose_output_scheduler.
//
// A queue-based model describes each drain as a list of events (columns
// 0..n-1, then a flush slot, then the done slot) and checks the DUT on every
// negedge; directed sequences with literal expectations pin the model.
module tb_transpose_output_scheduler;

  localparam int Dimension = 16;
  localparam int CNT_W     = 5;

  logic clk;
  logic rst_n;

  transpose_output_scheduler_if #(.Dimension(Dimension), .CNT_W(CNT_W)) bus ();

  transpose_output_scheduler #(.Dimension(Dimension), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model state: pending drain events, -1 = flush slot, -2 = done slot
  int          evq[$];
  logic [15:0] expEn;
  int          expCol;
  logic        expBusy;
  logic        expDone;
  logic        colValid;

  task automatic modelClear();
    evq.delete();
    expEn    = '0;
    expCol   = 0;
    expBusy  = 1'b0;
    expDone  = 1'b0;
    colValid = 1'b0;
  endtask

  task automatic modelEmit(input int ev);
    expBusy = 1'b1;
    expDone = (ev == -2);
    if (ev >= 0) begin
      expEn    = 16'(1) << ev;
      expCol   = ev;
      colValid = 1'b1;
    end else begin
      expEn    = '0;
      colValid = 1'b0;
    end
  endtask

  // Advance the model by one clock edge (or apply an async reset).
  task automatic modelStep();
    int n;
    if (!rst_n || bus.abort) begin
      modelClear();
    end else if (!expBusy) begin
      expEn   = '0;
      expDone = 1'b0;
      if (bus.start) begin
        n = (int'(bus.num_cols) > Dimension) ? Dimension : int'(bus.num_cols);
        evq.delete();
        for (int i = 0; i < n; i++) evq.push_back(i);
        if (n > 0) evq.push_back(-1);
        evq.push_back(-2);
        modelEmit(evq.pop_front());
      end
    end else if (evq.size() == 0) begin
      modelClear();
    end else if (evq[0] >= 0 && bus.stall) begin
      expEn   = '0;
      expDone = 1'b0;
    end else begin
      modelEmit(evq.pop_front());
    end
  endtask

  initial begin
    modelClear();
    forever begin
      @(posedge clk or negedge rst_n);
      modelStep();
    end
  end

  // Every-cycle comparison of the DUT against the model.
  initial begin
    forever begin
      @(negedge clk);
      checks++;
      if (bus.en_output !== expEn || bus.busy !== expBusy || bus.done !== expDone) begin
        errors++;
        $display("[TB] FAIL model t=%0t: en_output=%h busy=%b done=%b, expected en_output=%h busy=%b done=%b",
                 $time, bus.en_output, bus.busy, bus.done, expEn, expBusy, expDone);
      end
      checks++;
      if (!$onehot0(bus.en_output)) begin
        errors++;
        $display("[TB] FAIL onehot t=%0t: en_output=%h, expected one-hot or zero", $time, bus.en_output);
      end
      if (colValid) begin
        checks++;
        if (int'(bus.cur_col) != expCol) begin
          errors++;
          $display("[TB] FAIL cur_col t=%0t: cur_col=%0d, expected %0d", $time, bus.cur_col, expCol);
        end
      end
    end
  end

  task automatic applyStimulus(input logic s, input logic [CNT_W-1:0] n,
                               input logic st, input logic ab);
    @(negedge clk);
    bus.start    = s;
    bus.num_cols = n;
    bus.stall    = st;
    bus.abort    = ab;
  endtask

  task automatic checkOutput(input string name, input logic [15:0] en,
                             input logic bsy, input logic dn);
    checks++;
    if (bus.en_output !== en || bus.busy !== bsy || bus.done !== dn) begin
      errors++;
      $display("[TB] FAIL %s: en_output=%h busy=%b done=%b, expected en_output=%h busy=%b done=%b",
               name, bus.en_output, bus.busy, bus.done, en, bsy, dn);
    end
  endtask

  task automatic checkValue(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  int enCount;
  int doneCount;
  logic [15:0] stallEn [7] = '{16'h0001, 16'h0000, 16'h0000, 16'h0002, 16'h0004, 16'h0000, 16'h0000};

  initial begin
    rst_n        = 1'b0;
    bus.start    = 1'b0;
    bus.num_cols = '0;
    bus.stall    = 1'b0;
    bus.abort    = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("reset", 16'h0000, 1'b0, 1'b0);
    checkValue("resetCurCol", int'(bus.cur_col), 0);
    rst_n = 1'b1;
    applyStimulus(0, 0, 0, 0);

    $display("[TB] full 16-column drain");
    applyStimulus(1, 16, 0, 0);
    for (int c = 1; c <= 19; c++) begin
      applyStimulus(0, 16, 0, 0);
      if (c <= 16)      checkOutput($sformatf("full c%0d", c), 16'(1) << (c - 1), 1'b1, 1'b0);
      else if (c == 17) checkOutput("full flush", 16'h0000, 1'b1, 1'b0);
      else if (c == 18) checkOutput("full done", 16'h0000, 1'b1, 1'b1);
      else              checkOutput("full idle", 16'h0000, 1'b0, 1'b0);
    end

    $display("[TB] 3 columns with stall");
    applyStimulus(1, 3, 0, 0);
    enCount = 0;
    for (int c = 1; c <= 7; c++) begin
      applyStimulus(0, 3, (c == 1 || c == 2), 0);
      if (bus.en_output != 0) enCount++;
      checkOutput($sformatf("stall c%0d", c), stallEn[c-1], 1'b1, (c == 7));
    end
    checkValue("stallEnables", enCount, 3);
    applyStimulus(0, 0, 0, 0);

    $display("[TB] zero columns");
    applyStimulus(1, 0, 0, 0);
    applyStimulus(0, 0, 0, 0);
    checkOutput("zero done", 16'h0000, 1'b1, 1'b1);
    applyStimulus(0, 0, 0, 0);
    checkOutput("zero idle", 16'h0000, 1'b0, 1'b0);

    $display("[TB] clamped 20 columns");
    applyStimulus(1, 20, 0, 0);
    enCount = 0;
    for (int c = 1; c <= 19; c++) begin
      applyStimulus(0, 20, 0, 0);
      if (bus.en_output != 0) enCount++;
      if (c == 16) checkOutput("clamp last", 16'h8000, 1'b1, 1'b0);
      if (c == 18) checkOutput("clamp done", 16'h0000, 1'b1, 1'b1);
    end
    checkValue("clampEnables", enCount, 16);

    $display("[TB] start ignored while busy");
    applyStimulus(1, 4, 0, 0);
    enCount   = 0;
    doneCount = 0;
    for (int c = 1; c <= 10; c++) begin
      applyStimulus((c == 2 || c == 6), 9, 0, 0);
      if (bus.en_output != 0) enCount++;
      if (bus.done) doneCount++;
      if (c == 4) checkOutput("ignore last", 16'h0008, 1'b1, 1'b0);
      if (c == 6) checkOutput("ignore done", 16'h0000, 1'b1, 1'b1);
      if (c == 8) checkOutput("ignore idle", 16'h0000, 1'b0, 1'b0);
    end
    checkValue("ignoreEnables", enCount, 4);
    checkValue("ignoreDones", doneCount, 1);

    $display("[TB] abort mid-drain");
    applyStimulus(1, 10, 0, 0);
    for (int c = 1; c <= 6; c++) applyStimulus(0, 10, 0, (c == 6));
    checkOutput("abort before", 16'h0020, 1'b1, 1'b0);
    doneCount = 0;
    for (int c = 7; c <= 10; c++) begin
      applyStimulus(0, 10, 0, 0);
      if (bus.done) doneCount++;
      if (c == 7) checkOutput("abort after", 16'h0000, 1'b0, 1'b0);
    end
    checkValue("abortDones", doneCount, 0);
    applyStimulus(1, 2, 0, 0);
    applyStimulus(0, 2, 0, 0);
    checkOutput("restart c1", 16'h0001, 1'b1, 1'b0);
    applyStimulus(0, 2, 0, 0);
    checkOutput("restart c2", 16'h0002, 1'b1, 1'b0);
    applyStimulus(0, 2, 0, 0);
    checkOutput("restart flush", 16'h0000, 1'b1, 1'b0);
    applyStimulus(0, 2, 0, 0);
    checkOutput("restart done", 16'h0000, 1'b1, 1'b1);

    $display("[TB] async reset mid-drain");
    applyStimulus(0, 0, 0, 0);
    applyStimulus(1, 16, 0, 0);
    for (int c = 1; c <= 9; c++) applyStimulus(0, 16, 0, 0);
    checkOutput("rst before", 16'h0100, 1'b1, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("rst immediate", 16'h0000, 1'b0, 1'b0);
    checkValue("rstCurCol", int'(bus.cur_col), 0);
    applyStimulus(0, 16, 0, 0);
    applyStimulus(0, 16, 0, 0);
    rst_n     = 1'b1;
    doneCount = 0;
    enCount   = 0;
    for (int c = 0; c < 20; c++) begin
      applyStimulus(0, 16, 0, 0);
      if (bus.done) doneCount++;
      if (bus.en_output != 0 || bus.busy) enCount++;
    end
    checkValue("postRstDones", doneCount, 0);
    checkValue("postRstActive", enCount, 0);

    applyStimulus(0, 0, 0, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
